spi_cmd_receiver: RTL

Front end of the Logic Sniffer host interface. It receives bytes from the PIC over SPI (sclk/mosi/cs) in the system clock domain and assembles them into complete commands. Short commands are opcodes 0x00-0x7F with no argument. Long commands are opcodes 0x80-0xFF followed by 4 argument bytes, least-significant byte first. Each finished command goes to the downstream command decoder as a single-cycle strobe.

---
 rtl/ols_cmd_pkg.sv | 24 ++
 rtl/spi_bit_sync.sv | 42 ++++
 rtl/spi_cmd_receiver.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ols_cmd_pkg.sv
// Shared types and constants for the Logic Sniffer SPI command front end.
package ols_cmd_pkg;

    typedef enum logic [0:0] {
        S_OPCODE = 1'b0,
        S_ARG    = 1'b1
    } cmd_state_e;

    localparam int LONG_OPCODE_BIT = 7;
    localparam int ARG_BYTES       = 4;

    localparam logic [7:0] CMD_RESET      = 8'h00;
    localparam logic [7:0] CMD_RUN        = 8'h01;
    localparam logic [7:0] CMD_ID         = 8'h02;
    localparam logic [7:0] CMD_META       = 8'h04;
    localparam logic [7:0] CMD_RLE_FINISH = 8'h05;
    localparam logic [7:0] CMD_DIVIDER    = 8'h80;
    localparam logic [7:0] CMD_COUNTS     = 8'h81;
    localparam logic [7:0] CMD_FLAGS      = 8'h82;
    localparam logic [7:0] CMD_TRIG_MASK0 = 8'hC0;
    localparam logic [7:0] CMD_TRIG_VAL0  = 8'hC1;
    localparam logic [7:0] CMD_TRIG_CFG0  = 8'hC2;

endpackage

// File: rtl/spi_bit_sync.sv
// Brings the asynchronous SPI pins into the system clock domain and
// flags rising edges of sclk.
module spi_bit_sync (
    input  logic clock,
    input  logic reset,
    input  logic sclk,
    input  logic mosi,
    input  logic cs,
    output logic sclk_rise,
    output logic mosi_s,
    output logic cs_s
);

    logic sclk_p0, sclk_p1, sclk_p2;
    logic mosi_p0, mosi_p1;
    logic cs_p0, cs_p1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
        end else begin
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
            cs_p0   <= cs;
            cs_p1   <= cs_p0;
        end
    end

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign mosi_s    = mosi_p1;
    assign cs_s      = cs_p1;

endmodule

// File: rtl/spi_cmd_receiver.sv
// Assembles SPI bytes from the PIC into short (opcode only) and long
// (opcode + 4 LSB-first argument bytes) commands with an inter-byte timeout.
module spi_cmd_receiver
    import ols_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TIMEOUT_W      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_opcode,
    output logic [31:0] cmd_data,
    output logic        cmd_long,
    output logic        busy,
    output logic        cmd_abort
);

    logic sclk_rise, mosi_s, cs_s;

    spi_bit_sync u_sync (
        .clock     (clock),
        .reset     (reset),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs        (cs),
        .sclk_rise (sclk_rise),
        .mosi_s    (mosi_s),
        .cs_s      (cs_s)
    );

    // Stage p0: bit shift and byte framing
    logic [2:0] bit_cnt;
    logic [7:0] shift_p0;
    logic       vld_p0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt <= 3'd0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (cs_s) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                vld_p0  <= (bit_cnt == 3'd7);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (sclk_rise && !cs_s)
            shift_p0 <= {shift_p0[6:0], mosi_s};
    end

    // Stage p1: byte output register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
        end else begin
            byte_valid <= vld_p0;
            if (vld_p0)
                byte_data <= shift_p0;
        end
    end

    // Stage p2: command assembly
    cmd_state_e           state, state_nx;
    logic [1:0]           arg_cnt, arg_cnt_nx;
    logic [7:0]           opcode_q, opcode_nx;
    logic [31:0]          arg_q, arg_nx;
    logic [TIMEOUT_W-1:0] tmo_cnt, tmo_nx;
    logic                 cmd_valid_nx, cmd_long_nx, cmd_abort_nx;
    logic [7:0]           cmd_opcode_nx;
    logic [31:0]          cmd_data_nx;

    always_comb begin
        state_nx      = state;
        arg_cnt_nx    = arg_cnt;
        opcode_nx     = opcode_q;
        arg_nx        = arg_q;
        cmd_valid_nx  = 1'b0;
        cmd_abort_nx  = 1'b0;
        cmd_opcode_nx = cmd_opcode;
        cmd_data_nx   = cmd_data;
        cmd_long_nx   = cmd_long;

        case (state)
            S_OPCODE: begin
                if (byte_valid) begin
                    if (!byte_data[LONG_OPCODE_BIT]) begin
                        cmd_valid_nx  = 1'b1;
                        cmd_opcode_nx = byte_data;
                        cmd_data_nx   = 32'h0;
                        cmd_long_nx   = 1'b0;
                    end else begin
                        opcode_nx  = byte_data;
                        arg_cnt_nx = 2'd0;
                        arg_nx     = 32'h0;
                        state_nx   = S_ARG;
                    end
                end
            end
            S_ARG: begin
                // A byte arriving on the timeout cycle wins over the abort
                if (byte_valid) begin
                    arg_nx[{arg_cnt, 3'b000} +: 8] = byte_data;
                    if (arg_cnt == 2'(ARG_BYTES - 1)) begin
                        cmd_valid_nx  = 1'b1;
                        cmd_opcode_nx = opcode_q;
                        cmd_data_nx   = arg_nx;
                        cmd_long_nx   = 1'b1;
                        state_nx      = S_OPCODE;
                    end else begin
                        arg_cnt_nx = arg_cnt + 2'd1;
                    end
                end else if (tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
                    cmd_abort_nx = 1'b1;
                    state_nx     = S_OPCODE;
                end
            end
            default: state_nx = S_OPCODE;
        endcase

        tmo_nx = (state_nx == S_ARG && !byte_valid) ? tmo_cnt + 1'b1 : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_OPCODE;
            arg_cnt    <= 2'd0;
            tmo_cnt    <= '0;
            cmd_valid  <= 1'b0;
            cmd_abort  <= 1'b0;
            cmd_opcode <= 8'h00;
            cmd_data   <= 32'h0;
            cmd_long   <= 1'b0;
        end else begin
            state      <= state_nx;
            arg_cnt    <= arg_cnt_nx;
            tmo_cnt    <= tmo_nx;
            cmd_valid  <= cmd_valid_nx;
            cmd_abort  <= cmd_abort_nx;
            cmd_opcode <= cmd_opcode_nx;
            cmd_data   <= cmd_data_nx;
            cmd_long   <= cmd_long_nx;
        end
    end

    always_ff @(posedge clock) begin
        opcode_q <= opcode_nx;
        arg_q    <= arg_nx;
    end

    assign busy = (state == S_ARG);

endmodule
